key_schedule_ctrl: RTL and testbench

//  Sequential AES-128 key-schedule controller that sits upstream of inverse_key_expansion.
//  - Drives RC and the current round key into one instance of inverse_key_expansion.
//  - Consumes its 128-bit output, one round per clock.
//  - Stores round keys 0..10 in an internal register file.
//  - Serves them to the cipher/decipher datapath through a combinational read port.

---
 rtl/key_schedule_ctrl_if.sv | 13 +
 rtl/key_schedule_ctrl.sv | 154 +++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_ctrl_if.sv
// rtl/key_schedule_ctrl_if.sv - start/read/status bundle between key-schedule controller and its user
interface key_schedule_ctrl_if #(parameter int KW = 128);
  logic          start;
  logic [KW-1:0] key_in;
  logic [3:0]    rd_idx;
  logic [KW-1:0] rd_key;
  logic          busy;
  logic          done;
  logic          key_valid;

  modport master (output start, key_in, rd_idx, input rd_key, busy, done, key_valid);
  modport slave  (input start, key_in, rd_idx, output rd_key, busy, done, key_valid);
endinterface

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - sequential AES-128 key schedule, one round per clock, 11-slot register file
// KEY_SCHED_REVERSE_READ_EN: when defined, rd_idx maps to slot[NR-rd_idx] (decryption order).
module inverse_key_expansion (
  input  logic [127:0] in_i,
  input  logic [31:0]  rc_i,
  output logic [127:0] out_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: x^254 in GF(2^8) then the affine map, avoiding a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, v;
    t = gf_mul(gf_mul(x, x), x);          // x^3
    t = gf_mul(gf_mul(t, t), x);          // x^7
    t = gf_mul(gf_mul(t, t), x);          // x^15
    t = gf_mul(gf_mul(t, t), x);          // x^31
    t = gf_mul(gf_mul(t, t), x);          // x^63
    t = gf_mul(gf_mul(t, t), x);          // x^127
    v = gf_mul(t, t);                     // x^254
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] rot_w, tmp_w, o0, o1, o2, o3;

  always_comb begin
    rot_w = {in_i[23:0], in_i[31:24]};
    tmp_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])} ^ rc_i;
    o0    = in_i[127:96] ^ tmp_w;
    o1    = in_i[95:64]  ^ o0;
    o2    = in_i[63:32]  ^ o1;
    o3    = in_i[31:0]   ^ o2;
    out_o = {o0, o1, o2, o3};
  end
endmodule

module key_schedule_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  key_schedule_ctrl_if.slave ks_if
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    rc_q, rc_d;
  logic          kv_q, kv_d;
  logic [KW-1:0] slot_q [0:NR];

  logic          wr_en;
  logic [3:0]    wr_idx;
  logic [KW-1:0] wr_data;
  logic [3:0]    src_idx;
  logic [KW-1:0] exp_in, exp_out;
  logic [3:0]    rd_slot;

  always_comb begin
    src_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    exp_in  = (src_idx <= NR_L) ? slot_q[src_idx] : '0;
  end

  inverse_key_expansion u_kexp (
    .in_i  (exp_in),
    .rc_i  ({rc_q, 24'h000000}),
    .out_o (exp_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rc_q    <= 8'h01;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      kv_q    <= kv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    kv_d    = kv_q;
    wr_en   = 1'b0;
    wr_idx  = 4'd0;
    wr_data = exp_out;
    case (state_q)
      IDLE: begin
        if (ks_if.start) begin
          wr_en   = 1'b1;
          wr_data = ks_if.key_in;
          rc_d    = 8'h01;
          cnt_d   = 4'd1;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        rc_d   = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1B : 8'h00);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == NR_L) begin
          cnt_d   = 4'd0;
          kv_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) slot_q[i] <= '0;
    end else if (wr_en) begin
      slot_q[wr_idx] <= wr_data;
    end
  end

`ifdef KEY_SCHED_REVERSE_READ_EN
  assign rd_slot = NR_L - ks_if.rd_idx;
`else
  assign rd_slot = ks_if.rd_idx;
`endif

  // Range test is on the raw index so both read orders return zero above NR.
  always_comb begin
    ks_if.rd_key = '0;
    if (ks_if.rd_idx <= NR_L) ks_if.rd_key = slot_q[rd_slot];
  end

  assign ks_if.busy      = (state_q != IDLE);
  assign ks_if.done      = (state_q == DONE);
  assign ks_if.key_valid = kv_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - scoreboard bench for key_schedule_ctrl (FIPS-197 and corner keys)
module tb_key_schedule_ctrl;
  logic clk;
  logic rst_n;

  key_schedule_ctrl_if ks_if ();

  key_schedule_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks_if (ks_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ONES = {128{1'b1}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] map_idx(input int slot);
`ifdef KEY_SCHED_REVERSE_READ_EN
    return 4'(10 - slot);
`else
    return 4'(slot);
`endif
  endfunction

  task automatic push(input int slot, input logic [127:0] v);
    exp_t e;
    e.idx = 4'(slot);
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic push_fips();
    push(0,  K_FIPS);
    push(1,  128'ha0fafe1788542cb123a339392a6c7605);
    push(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ks_if.rd_idx = map_idx(int'(e.idx));
      #1;
      check($sformatf("slot%0d", e.idx), ks_if.rd_key, e.val);
    end
  endtask

  task automatic drive_start(input logic [127:0] k);
    @(negedge clk);
    ks_if.start  = 1'b1;
    ks_if.key_in = k;
    @(posedge clk);
    #1;
    ks_if.start  = 1'b0;
    ks_if.key_in = ~k;
  endtask

  // n counts rising edges from the start edge; done must be visible after the 11th.
  task automatic run_sched(input logic [127:0] k, input bit inj_mid, input bit inj_done);
    int n;
    drive_start(k);
    n = 1;
    @(negedge clk);
    check("busy_after_start", 128'(ks_if.busy), 128'd1);
    check("kv_drop_on_start", 128'(ks_if.key_valid), 128'd0);
    while (!ks_if.done && n < 40) begin
      if (inj_mid && n == 4) begin
        ks_if.start  = 1'b1;
        ks_if.key_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
      end else begin
        ks_if.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    ks_if.start = 1'b0;
    check("done_latency", 128'(n), 128'd11);
    check("kv_at_done", 128'(ks_if.key_valid), 128'd1);
    if (inj_done) ks_if.start = 1'b1;
    @(negedge clk);
    ks_if.start = 1'b0;
    check("done_one_cycle", 128'(ks_if.done), 128'd0);
    check("busy_after_done", 128'(ks_if.busy), 128'd0);
    check("kv_hold", 128'(ks_if.key_valid), 128'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 128'(ks_if.busy), 128'd0);
    check({tag, "_done"}, 128'(ks_if.done), 128'd0);
    check({tag, "_kv"}, 128'(ks_if.key_valid), 128'd0);
    for (int i = 0; i < 16; i++) begin
      ks_if.rd_idx = 4'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), ks_if.rd_key, 128'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] prev, cur;
    ks_if.start  = 1'b0;
    ks_if.key_in = '0;
    ks_if.rd_idx = 4'd0;
    rst_n = 1'b0;
    #23;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 key, plus a start held during the DONE cycle that must be ignored
    push_fips();
    run_sched(K_FIPS, 1'b0, 1'b1);
    drain_sb();

    // Each round key's last three words chain by XOR from the previous round key
    for (int i = 1; i <= 10; i++) begin
      ks_if.rd_idx = map_idx(i - 1);
      #1 prev = ks_if.rd_key;
      ks_if.rd_idx = map_idx(i);
      #1 cur = ks_if.rd_key;
      check($sformatf("chain%0d", i), cur[95:0],
            {prev[95:64] ^ cur[127:96], prev[63:32] ^ cur[95:64], prev[31:0] ^ cur[63:32]});
    end

    // Restart from a valid schedule with all-ones key
    push(0, K_ONES);
    push(1, 128'he8e9e9e917161616e8e9e9e917161616);
    run_sched(K_ONES, 1'b0, 1'b0);
    drain_sb();

    // Start mid-expansion with a different key is ignored
    push_fips();
    run_sched(K_FIPS, 1'b1, 1'b0);
    drain_sb();

    // Asynchronous reset during expansion aborts and clears everything
    push_fips();
    drive_start(K_ONES);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_fips();
    run_sched(K_FIPS, 1'b0, 1'b0);
    drain_sb();

    // All-zero key and reads above NR
    push(0, 128'd0);
    push(1, 128'h62636363626363636263636362636363);
    push(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run_sched(128'd0, 1'b0, 1'b0);
    drain_sb();
    for (int i = 11; i < 16; i++) begin
      ks_if.rd_idx = 4'(i);
      #1;
      check($sformatf("oob%0d", i), ks_if.rd_key, 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
